mux_nway_stream: RTL and testbench

Parametrised N-way, WIDTH-bit stream multiplexer with a registered output stage and valid/ready handshakes on every channel. Successor to the 4-way 16-bit combinational mux: it selects either by an explicit `sel` input or by round-robin arbitration, holds the chosen word in a one-entry output buffer, and reports which channel it came from. It sits between multiple producers and one consumer in the datapath.

---
 rtl/mux_nway_stream.sv | 105 ++++++++++
 tb/tb_mux_nway_stream.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux_nway_stream.sv
// ============================================================================
// Module   : mux_nway_stream
// Purpose  : N-way valid/ready stream mux, fixed-select or round-robin,
//            with a one-entry registered output buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_nway_stream #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             rr_en_i,
  input  logic [SW-1:0]    sel_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  input  logic [N-1:0]     in_valid_i,
  output logic [N-1:0]     in_ready_o,
  output logic [WIDTH-1:0] out_o,
  output logic [SW-1:0]    out_chan_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_q,   out_d;
  logic [SW-1:0]    chan_q,  chan_d;
  logic             valid_q, valid_d;
  logic [SW-1:0]    ptr_q,   ptr_d;

  logic [SW-1:0]    grant;
  logic             grant_vld;
  logic [SW-1:0]    cand;
  logic             load_en;
  logic             xfer;

  assign load_en = !valid_q || out_ready_i;

  // Descending scan so the nearest channel after ptr wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (rr_en_i) begin
      for (int k = N; k >= 1; k--) begin
        cand = SW'((int'(ptr_q) + k) % N);
        if (in_valid_i[cand]) begin
          grant     = cand;
          grant_vld = 1'b1;
        end
      end
    end else if (int'(sel_i) < N) begin
      if (in_valid_i[sel_i]) begin
        grant     = sel_i;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready_o = '0;
    if (grant_vld && !reset_i) begin
      in_ready_o[grant] = load_en;
    end
  end

  assign xfer = grant_vld && load_en;

  always_comb begin
    out_d   = out_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      out_d   = in_data_i[grant*WIDTH +: WIDTH];
      chan_d  = grant;
      valid_d = 1'b1;
      ptr_d   = grant;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_q   <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= SW'(N - 1);
    end else begin
      out_q   <= out_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_o       = out_q;
  assign out_chan_o  = chan_q;
  assign out_valid_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_nway_stream.sv
// ============================================================================
// Module   : tb_mux_nway_stream
// Purpose  : Directed self-checking bench for mux_nway_stream (N=4, WIDTH=16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux_nway_stream;

  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int SW    = 2;

  logic             clk;
  logic             reset;
  logic             rr_en;
  logic [SW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [WIDTH-1:0] out;
  logic [SW-1:0]    out_chan;
  logic             out_valid;
  logic             out_ready;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_data [4];
  logic [SW-1:0]    rr_seq   [8];

  mux_nway_stream #(.WIDTH(WIDTH), .N(N)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .rr_en_i     (rr_en),
    .sel_i       (sel),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_o       (out),
    .out_chan_o  (out_chan),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_data[0] = 16'hAAAA;
    exp_data[1] = 16'h5555;
    exp_data[2] = 16'hF0F0;
    exp_data[3] = 16'h0F0F;
    rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2; rr_seq[3] = 2'd3;
    rr_seq[4] = 2'd0; rr_seq[5] = 2'd1; rr_seq[6] = 2'd2; rr_seq[7] = 2'd3;

    reset     = 1'b1;
    rr_en     = 1'b0;
    sel       = '0;
    in_data   = {16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA};
    in_valid  = 4'hF;
    out_ready = 1'b1;

    // Reset state, with every channel requesting
    tick();
    tick();
    chk("rst_out",       32'(out),       32'h0);
    chk("rst_chan",      32'(out_chan),  32'h0);
    chk("rst_valid",     32'(out_valid), 32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Fixed select stepped 0..3
    for (int i = 0; i < 4; i++) begin
      sel = SW'(i);
      #1;
      chk("fix_in_ready", 32'(in_ready), 32'(4'b0001 << i));
      tick();
      chk("fix_out",   32'(out),       32'(exp_data[i]));
      chk("fix_chan",  32'(out_chan),  32'(i));
      chk("fix_valid", 32'(out_valid), 32'h1);
    end

    // Round-robin fairness, all valid (ptr now 3)
    rr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << rr_seq[i]));
      tick();
      chk("rr_chan", 32'(out_chan), 32'(rr_seq[i]));
      chk("rr_out",  32'(out),      32'(exp_data[rr_seq[i]]));
    end

    // Sparse round-robin: ch1 and ch3 only
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sparse_in_ready", 32'(in_ready), (i % 2 == 0) ? 32'h2 : 32'h8);
      tick();
      chk("sparse_out", 32'(out), (i % 2 == 0) ? 32'h5555 : 32'h0F0F);
    end

    // Drain to EMPTY
    in_valid = 4'b0000;
    #1;
    chk("drain_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_out_hold", 32'(out), 32'h0F0F);

    // Backpressure: load AAAA, then stall three cycles
    in_valid = 4'hF;
    tick();
    chk("bp_first_out", 32'(out), 32'hAAAA);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bp_out",   32'(out),       32'hAAAA);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_chan",  32'(out_chan),  32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'h2);
    tick();
    chk("bp_next_out",  32'(out),      32'h5555);
    chk("bp_next_chan", 32'(out_chan), 32'h1);
    in_valid = 4'h0;
    tick();
    chk("bp_no_dup_valid", 32'(out_valid), 32'h0);

    // Invalid select: buffer 0F0F, then select an idle channel
    rr_en    = 1'b0;
    sel      = 2'd3;
    in_valid = 4'hF;
    tick();
    chk("inv_load_out", 32'(out), 32'h0F0F);
    sel       = 2'd2;
    in_valid  = 4'b1011;
    out_ready = 1'b0;
    #1;
    chk("inv_in_ready_full", 32'(in_ready), 32'h0);
    tick();
    out_ready = 1'b1;
    #1;
    chk("inv_in_ready_open", 32'(in_ready), 32'h0);
    tick();
    chk("inv_valid_fall", 32'(out_valid), 32'h0);
    chk("inv_out_hold",   32'(out),       32'h0F0F);
    chk("inv_chan_hold",  32'(out_chan),  32'h3);

    // Async reset mid-cycle while FULL with F0F0
    in_valid = 4'hF;
    tick();
    chk("ar_load_out", 32'(out), 32'hF0F0);
    out_ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("ar_out",      32'(out),       32'h0);
    chk("ar_chan",     32'(out_chan),  32'h0);
    chk("ar_valid",    32'(out_valid), 32'h0);
    chk("ar_in_ready", 32'(in_ready),  32'h0);
    tick();
    @(negedge clk);
    reset     = 1'b0;
    rr_en     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("ar_first_chan", 32'(out_chan),  32'h0);
    chk("ar_first_out",  32'(out),       32'hAAAA);
    chk("ar_first_vld",  32'(out_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
